// File: rtl/i2c_pkg.sv
// Shared types and default timing for the serial memory-bus initiator.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, RW, ADDR_ACK, TURN, DATA, DATA_ACK,
        RD_WAIT, STOP_LO, STOP_HI, DONE
    } state_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    localparam int DEF_ADDR_WIDTH       = 7;
    localparam int DEF_DATA_WIDTH       = 8;
    localparam int DEF_TURN_CYCLES      = 2;
    localparam int DEF_RD_WAIT_CYCLES   = 2;
    localparam int DEF_ACK_TIMEOUT      = 4;
    localparam int DEF_STOP_HIGH_CYCLES = 2;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/i2c_bit_serializer.sv
// Loadable LSB-first shifter; o_last flags the final bit of the loaded length.
module i2c_bit_serializer #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_load,
    input  logic [W-1:0]  i_data,
    input  logic [CW-1:0] i_len,
    input  logic          i_shift,
    output logic          o_bit,
    output logic          o_last
);

    logic [W-1:0]  r_data;
    logic [CW-1:0] r_idx;
    logic [CW-1:0] r_len;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= '0;
            r_idx  <= '0;
            r_len  <= '0;
        end else if (i_load) begin
            r_data <= i_data;
            r_idx  <= '0;
            r_len  <= i_len;
        end else if (i_shift) begin
            r_data <= r_data >> 1;
            r_idx  <= r_idx + 1'b1;
        end
    end

    assign o_bit  = r_data[0];
    assign o_last = (r_idx == r_len - 1'b1);

endmodule

// File: rtl/i2c_master_controller.sv
// Serializes one read/write command per frame onto SDA_OUT, one bit per clk,
// with ack timeouts, read-data capture and a fixed stop sequence.
module i2c_master_controller
    import i2c_pkg::*;
#(
    parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int TURN_CYCLES      = DEF_TURN_CYCLES,
    parameter int RD_WAIT_CYCLES   = DEF_RD_WAIT_CYCLES,
    parameter int ACK_TIMEOUT      = DEF_ACK_TIMEOUT,
    parameter int STOP_HIGH_CYCLES = DEF_STOP_HIGH_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  rw,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ack_n,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  SDA_OUT,
    output logic                  busy,
    output logic                  done,
    output logic                  nack,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int SER_W   = max2(ADDR_WIDTH, DATA_WIDTH);
    localparam int BIT_CW  = $clog2(SER_W) + 1;
    localparam int CNT_MAX = max2(max2(TURN_CYCLES, RD_WAIT_CYCLES),
                                  max2(ACK_TIMEOUT, STOP_HIGH_CYCLES));
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    state_e                r_state, w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_rw;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_nack;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_accept, w_sda, w_in_ack, w_ack_ok, w_ack_to;
    logic                  w_ser_load, w_ser_shift, w_ser_bit, w_ser_last;
    logic [SER_W-1:0]      w_ser_data;
    logic [BIT_CW-1:0]     w_ser_len;
    logic                  w_rd_cap;

    assign busy     = (r_state != IDLE) && (r_state != DONE);
    assign done     = (r_state == DONE);
    assign w_accept = start && !busy;
    assign w_in_ack = (r_state == ADDR_ACK) || (r_state == DATA_ACK);
    assign w_ack_ok = w_in_ack && !ack_n;
    assign w_ack_to = w_in_ack && ack_n && (r_cnt == CNT_W'(ACK_TIMEOUT - 1));
    assign w_rd_cap = (r_state == RD_WAIT) && (r_cnt == CNT_W'(RD_WAIT_CYCLES - 1));

    // The single shifter carries the address first, then is reloaded with
    // write data at the address ack so it is ready by the end of TURN.
    assign w_ser_load = w_accept ||
                        ((r_state == ADDR_ACK) && w_ack_ok && (r_rw == RW_WRITE));
    assign w_ser_data = w_accept ? SER_W'(addr) : SER_W'(r_wdata);
    assign w_ser_len  = w_accept ? BIT_CW'(ADDR_WIDTH) : BIT_CW'(DATA_WIDTH);

    i2c_bit_serializer #(.W(SER_W), .CW(BIT_CW)) u_ser (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_ser_load),
        .i_data  (w_ser_data),
        .i_len   (w_ser_len),
        .i_shift (w_ser_shift),
        .o_bit   (w_ser_bit),
        .o_last  (w_ser_last)
    );

    always_comb begin
        w_next      = r_state;
        w_sda       = 1'b1;
        w_ser_shift = 1'b0;
        case (r_state)
            IDLE:     if (w_accept) w_next = START;
            START: begin
                w_sda  = 1'b0;
                w_next = ADDR;
            end
            ADDR: begin
                w_sda       = w_ser_bit;
                w_ser_shift = 1'b1;
                if (w_ser_last) w_next = RW;
            end
            RW: begin
                w_sda  = r_rw;
                w_next = ADDR_ACK;
            end
            ADDR_ACK: begin
                if (w_ack_ok)      w_next = (r_rw == RW_WRITE) ? TURN : RD_WAIT;
                else if (w_ack_to) w_next = STOP_LO;
            end
            TURN:     if (r_cnt == CNT_W'(TURN_CYCLES - 1)) w_next = DATA;
            DATA: begin
                w_sda       = w_ser_bit;
                w_ser_shift = 1'b1;
                if (w_ser_last) w_next = DATA_ACK;
            end
            DATA_ACK: if (w_ack_ok || w_ack_to) w_next = STOP_LO;
            RD_WAIT:  if (w_rd_cap) w_next = STOP_LO;
            STOP_LO: begin
                w_sda  = 1'b0;
                w_next = STOP_HI;
            end
            STOP_HI:  if (r_cnt == CNT_W'(STOP_HIGH_CYCLES - 1)) w_next = DONE;
            DONE:     w_next = w_accept ? START : IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // r_cnt restarts on every state change, so each timed phase counts from 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rw    <= 1'b0;
            r_wdata <= '0;
            r_nack  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= ((w_next != r_state) || (r_state == IDLE)) ? '0 : r_cnt + 1'b1;
            if (w_accept) begin
                r_rw    <= rw;
                r_wdata <= wdata;
                r_nack  <= 1'b0;
            end else if (w_ack_to) begin
                r_nack  <= 1'b1;
            end
            if (w_rd_cap) r_rdata <= data_out;
        end
    end

    assign SDA_OUT = w_sda;
    assign nack    = r_nack;
    assign rdata   = r_rdata;

endmodule
